// File: rtl/store_align_unit.sv
// Store alignment: lane-positions store data and byte enables onto the memory bus.
// STORE_ALIGN_MISALIGN_SPLIT_EN: split line-crossing stores into two beats instead of dropping them.
module store_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic [ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_data_in,
  input  logic [2:0]              req_func_in,
  output logic                    mem_valid_out,
  input  logic                    mem_ready_in,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic [DATA_WIDTH/8-1:0] mem_wea_out,
  output logic                    fault_out
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  state_t state;

  logic [OW-1:0]           off;
  logic [OW+1:0]           size;
  logic [OW+1:0]           span;
  logic [7:0]              mask8;
  logic [2*NB-1:0]         mask_w;
  logic [2*DATA_WIDTH-1:0] data_w;
  logic [ADDR_WIDTH-1:0]   base;
  logic                    illegal;
  logic                    crossing;
  logic                    drop;
  logic                    accept;
  logic                    hs;

  logic [ADDR_WIDTH-1:0]   b1_addr;
  logic [DATA_WIDTH-1:0]   b1_data;
  logic [NB-1:0]           b1_wea;

  assign off  = req_addr_in[OW-1:0];
  assign base = {req_addr_in[ADDR_WIDTH-1:OW], OW'(0)};

  always_comb begin
    size  = '0;
    mask8 = '0;
    unique case (req_func_in[1:0])
      2'b00: begin size = (OW+2)'(1); mask8 = 8'h01; end
      2'b01: begin size = (OW+2)'(2); mask8 = 8'h03; end
      2'b10: begin size = (OW+2)'(4); mask8 = 8'h0f; end
      2'b11: begin size = (OW+2)'(8); mask8 = 8'hff; end
    endcase
  end

  // Double-width shifts: low half is beat 0, high half spills into beat 1
  assign mask_w = (2*NB)'(mask8) << off;
  assign data_w = {{DATA_WIDTH{1'b0}}, req_data_in} << {off, 3'b000};

  assign span     = (OW+2)'(off) + size;
  assign crossing = span > (OW+2)'(NB);
  assign illegal  = req_func_in[2] | ((&req_func_in[1:0]) & (NB < 8));
  assign drop     = illegal | (crossing & ~SPLIT_EN);

  assign hs            = mem_valid_out & mem_ready_in;
  assign req_ready_out = (state == IDLE) & (~mem_valid_out | mem_ready_in);
  assign accept        = req_valid_in & req_ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_valid_out <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      mem_wea_out   <= '0;
      fault_out     <= 1'b0;
      b1_addr       <= '0;
      b1_data       <= '0;
      b1_wea        <= '0;
    end else begin
      fault_out <= accept & drop;
      if (accept && !drop) begin
        mem_valid_out <= 1'b1;
        mem_addr_out  <= base;
        mem_data_out  <= data_w[DATA_WIDTH-1:0];
        mem_wea_out   <= mask_w[NB-1:0];
        if (crossing) begin
          state   <= SECOND;
          b1_addr <= base + ADDR_WIDTH'(NB);
          b1_data <= data_w[2*DATA_WIDTH-1:DATA_WIDTH];
          b1_wea  <= mask_w[2*NB-1:NB];
        end
      end else if (state == SECOND && hs) begin
        state         <= IDLE;
        mem_valid_out <= 1'b1;
        mem_addr_out  <= b1_addr;
        mem_data_out  <= b1_data;
        mem_wea_out   <= b1_wea;
      end else if (hs) begin
        mem_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: queue-based beat model plus directed literal checks.
// Follows STORE_ALIGN_MISALIGN_SPLIT_EN the same way the design does.
module tb_store_align_unit;

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [31:0] req_addr_in = '0;
  logic [31:0] req_data_in = '0;
  logic [2:0]  req_func_in = '0;
  logic        mem_valid_out;
  logic        mem_ready_in = 1'b1;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_wea_out;
  logic        fault_out;

  logic        c_req_valid = 1'b0;
  logic        c_req_ready;
  logic [31:0] c_req_addr = '0;
  logic [63:0] c_req_data = '0;
  logic [2:0]  c_req_func = '0;
  logic        c_mem_valid;
  logic [31:0] c_mem_addr;
  logic [63:0] c_mem_data;
  logic [7:0]  c_mem_wea;
  logic        c_fault;

  int passed = 0;
  int total = 0;

  beat_t q[$];
  bit    m_fault = 1'b0;

  always #5 clk = ~clk;

  store_align_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_func_in(req_func_in),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_wea_out(mem_wea_out), .fault_out(fault_out)
  );

  store_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(c_req_valid), .req_ready_out(c_req_ready),
    .req_addr_in(c_req_addr), .req_data_in(c_req_data),
    .req_func_in(c_req_func),
    .mem_valid_out(c_mem_valid), .mem_ready_in(1'b1),
    .mem_addr_out(c_mem_addr), .mem_data_out(c_mem_data),
    .mem_wea_out(c_mem_wea), .fault_out(c_fault)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Byte-level view of a store: which lanes of which beats it touches
  task automatic mk(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f, output bit drop, output int n,
                    output beat_t b0, output beat_t b1);
    int s;
    int o;
    logic [63:0] wide;
    logic [7:0]  w;
    s = 1 << f[1:0];
    o = int'(a[1:0]);
    drop = f[2] || (f[1:0] == 2'b11);
    n = (o + s > 4) ? 2 : 1;
    if (n == 2 && !SPLIT) drop = 1'b1;
    wide = {32'h0, d} << (8 * o);
    w = '0;
    for (int i = 0; i < s; i++)
      if (o + i < 8) w[o+i] = 1'b1;
    b0.a = a & ~32'h3;
    b0.d = wide[31:0];
    b0.w = w[3:0];
    b1.a = (a & ~32'h3) + 32'd4;
    b1.d = wide[63:32];
    b1.w = w[7:4];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_fault = 1'b0;
      end else begin
        bit    rdy;
        bit    drop;
        int    n;
        beat_t b0;
        beat_t b1;
        rdy = (q.size() == 0) || (q.size() == 1 && mem_ready_in);
        if (q.size() > 0 && mem_ready_in) void'(q.pop_front());
        m_fault = 1'b0;
        if (req_valid_in && rdy) begin
          mk(req_addr_in, req_data_in, req_func_in, drop, n, b0, b1);
          if (drop) m_fault = 1'b1;
          else begin
            q.push_back(b0);
            if (n == 2) q.push_back(b1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_ready", req_ready_out,
            (q.size() == 0) || (q.size() == 1 && mem_ready_in));
        chk("m_valid", mem_valid_out, q.size() > 0);
        chk("m_fault", fault_out, m_fault);
        if (q.size() > 0) begin
          chk("m_addr", mem_addr_out, q[0].a);
          chk("m_data", mem_data_out, q[0].d);
          chk("m_wea", mem_wea_out, q[0].w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f);
    bit ok;
    ok = 1'b0;
    req_valid_in = 1'b1;
    req_addr_in = a;
    req_data_in = d;
    req_func_in = f;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic beat(input string nm, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] w);
    chk({nm, "_valid"}, mem_valid_out, 1);
    chk({nm, "_addr"}, mem_addr_out, a);
    chk({nm, "_data"}, mem_data_out, d);
    chk({nm, "_wea"}, mem_wea_out, w);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", mem_valid_out, 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_wea", mem_wea_out, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready_out, 1);
    tick();

    send(32'h100, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    beat("sw", 32'h100, 32'hDEADBEEF, 4'b1111);
    send(32'h103, 32'h000000AB, 3'b000);
    @(negedge clk);
    beat("sb", 32'h100, 32'hAB000000, 4'b1000);
    send(32'h101, 32'h00001234, 3'b001);
    @(negedge clk);
    beat("sh", 32'h100, 32'h00123400, 4'b0110);

    for (int k = 0; k < 4; k++)
      send(32'h10 + k, 32'h11 * (k + 1), 3'b000);
    @(negedge clk);
    beat("b2b_last", 32'h10, 32'h44000000, 4'b1000);

    send(32'h102, 32'hAABBCCDD, 3'b010);
    @(negedge clk);
    if (SPLIT) begin
      beat("split0", 32'h100, 32'hCCDD0000, 4'b1100);
      chk("split_ready0", req_ready_out, 0);
      @(negedge clk);
      beat("split1", 32'h104, 32'h0000AABB, 4'b0011);
      chk("split_ready1", req_ready_out, 1);
    end else begin
      chk("cross_fault", fault_out, 1);
      chk("cross_novalid", mem_valid_out, 0);
      @(negedge clk);
      chk("cross_fault_end", fault_out, 0);
    end

    tick();
    mem_ready_in = 1'b0;
    send(32'h200, 32'h55667788, 3'b010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      beat("stall", 32'h200, 32'h55667788, 4'b1111);
      chk("stall_ready", req_ready_out, 0);
    end
    tick();
    mem_ready_in = 1'b1;
    req_valid_in = 1'b1;
    req_addr_in = 32'h204;
    req_data_in = 32'h00000099;
    req_func_in = 3'b010;
    @(negedge clk);
    chk("hs_ready", req_ready_out, 1);
    tick();
    req_valid_in = 1'b0;
    @(negedge clk);
    beat("after_stall", 32'h204, 32'h00000099, 4'b1111);

    send(32'h300, 32'h0, 3'b111);
    @(negedge clk);
    chk("ill_fault", fault_out, 1);
    chk("ill_novalid", mem_valid_out, 0);
    @(negedge clk);
    chk("ill_fault_end", fault_out, 0);
    send(32'h300, 32'h0, 3'b011);
    @(negedge clk);
    chk("sd32_fault", fault_out, 1);

    tick();
    mem_ready_in = 1'b0;
    send(SPLIT ? 32'h402 : 32'h400, 32'h11223344, 3'b010);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", mem_valid_out, 0);
    chk("rst_mid_wea", mem_wea_out, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    mem_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_beat", mem_valid_out, 0);
    end

    tick();
    c_req_valid = 1'b1;
    c_req_addr = 32'h8;
    c_req_data = 64'h0123456789ABCDEF;
    c_req_func = 3'b011;
    @(negedge clk);
    chk("sd_ready", c_req_ready, 1);
    tick();
    c_req_valid = 1'b0;
    @(negedge clk);
    chk("sd_valid", c_mem_valid, 1);
    chk("sd_addr", c_mem_addr, 32'h8);
    chk("sd_data", c_mem_data, 64'h0123456789ABCDEF);
    chk("sd_wea", c_mem_wea, 8'hFF);
    c_req_valid = 1'b1;
    c_req_addr = 32'hD;
    c_req_data = 64'hBEEF;
    c_req_func = 3'b001;
    tick();
    c_req_valid = 1'b0;
    @(negedge clk);
    chk("sh64_addr", c_mem_addr, 32'h8);
    chk("sh64_data", c_mem_data, 64'h00BEEF0000000000);
    chk("sh64_wea", c_mem_wea, 8'h60);
    @(negedge clk);
    chk("sh64_drop", c_mem_valid, 0);
    chk("sh64_fault", c_fault, 0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_in  in  1  store request valid.
REQ-006 SHALL have port req_ready_out  out  1  request accepted when valid&&ready.
REQ-007 SHALL have port req_addr_in  in  ADDR_WIDTH  byte address.
REQ-008 SHALL have port req_data_in  in  DATA_WIDTH  store data, LSB-justified.
REQ-009 SHALL have port req_func_in  in  3  funct3: 000 SB, 001 SH, 010 SW, 011 SD (SD legal only when DATA_WIDTH=64).
REQ-010 SHALL have port mem_valid_out  out  1  write beat valid.
REQ-011 SHALL have port mem_ready_in  in  1  memory accepts beat when valid&&ready.
REQ-012 SHALL have port mem_addr_out  out  ADDR_WIDTH  beat address, aligned to DATA_WIDTH/8 bytes.
REQ-013 SHALL have port mem_data_out  out  DATA_WIDTH  lane-positioned write data.
REQ-014 SHALL have port mem_wea_out  out  DATA_WIDTH/8  per-byte write enables.
REQ-015 SHALL have port fault_out  out  1  one-cycle pulse on dropped request.

Function
REQ-016 SHALL define NB=DATA_WIDTH/8, size S=1<<req_func_in[1:0] bytes, offset O=req_addr_in[log2(NB)-1:0], base = req_addr_in with offset bits cleared.
REQ-017 SHALL place beat-0 data = req_data_in << 8*O and wea = ((1<<S)-1) << O, both truncated to NB lanes; sub-word stores at any offset with O+S<=NB SHALL be a single beat (no forced halfword alignment).
REQ-018 SHALL assert req_ready_out only in state IDLE with output register empty or draining (!mem_valid_out || mem_ready_in).
REQ-019 SHALL present an accepted request's first beat in the cycle after acceptance (latency 1); back-to-back single-beat stores SHALL sustain one per cycle.
REQ-020 SHALL hold mem_valid_out, mem_addr_out, mem_data_out, mem_wea_out stable while mem_valid_out && !mem_ready_in.
REQ-021 SHALL treat a request as crossing when O+S>NB.
REQ-022 SHALL use states IDLE and SECOND; IDLE->SECOND on accepting a crossing request (macro enabled); SECOND->IDLE when the second beat is loaded into the output register.
REQ-023 In SECOND, upon beat-0 handshake, SHALL load beat 1: addr base+NB (modulo 2^ADDR_WIDTH), data req_data >> 8*(NB-O), wea full-size mask >> (NB-O).
REQ-024 SHALL drop an accepted request with illegal req_func_in (bit2 set, or 011 when DATA_WIDTH=32): no beat, fault_out high for exactly the cycle after acceptance.
REQ-025 SHALL deassert fault_out in all other cycles; mem_valid_out SHALL drop after handshake when no new beat is loaded.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, mem_valid_out 0, fault_out 0, mem_addr_out/mem_data_out/mem_wea_out 0.
REQ-027 Reset in SECOND or with a beat pending SHALL discard that beat and any stored second beat; no beat issued after release until a new request.
REQ-028 req_ready_out SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro STORE_ALIGN_MISALIGN_SPLIT_EN defined: crossing requests SHALL be split into two beats per REQ-022/023.
REQ-030 Macro undefined: crossing requests SHALL be accepted and dropped with fault_out pulse per REQ-024, and state SECOND SHALL never be entered.

Verification
REQ-031 SW addr 0x100 data 0xDEADBEEF, mem_ready_in=1 -> next cycle addr 0x100, data 0xDEADBEEF, wea 1111.
REQ-032 SB addr 0x103 data 0x000000AB -> addr 0x100, data 0xAB000000, wea 1000; SH addr 0x101 data 0x1234 -> data 0x00123400, wea 0110.
REQ-033 Macro on: SW addr 0x102 data 0xAABBCCDD -> beat0 addr 0x100 data 0xCCDD0000 wea 1100, then beat1 addr 0x104 data 0x0000AABB wea 0011; req_ready_out low until beat1 loaded. Macro off: no beat, fault_out one pulse.
REQ-034 mem_ready_in low 3 cycles with beat pending -> all mem_* outputs stable, req_ready_out low; new request accepted in handshake cycle.
REQ-035 req_func_in=111 -> no beat, fault_out pulse; DATA_WIDTH=64 SD addr 0x8 data 0x0123456789ABCDEF -> one beat, wea 0xFF.
REQ-036 rst_n low during SECOND -> mem_valid_out 0 immediately; no second beat after release.
